// File: rtl/line_buffer_mc_if.sv
// Pixel stream bundle: data plus dv/hs/vs timing strobes.
interface line_buffer_mc_if #(
  parameter int W = 24
) ();
  logic [W-1:0] data;
  logic         dv;
  logic         hs;
  logic         vs;

  modport master (
    output data, dv, hs, vs
  );

  modport slave (
    input data, dv, hs, vs
  );
endinterface

// File: rtl/line_buffer_mc.sv
// Multi-channel sliding-window line buffer: presents one column of the
// current line and BUF_DEPTH-1 previous lines, with frame-aware validity.
module line_buffer_mc #(
  parameter int COLORDEPTH  = 8,
  parameter int CHANNELS    = 3,
  parameter int SCREENWIDTH = 1600,
  parameter int BUF_DEPTH   = 3,
  parameter int BORDER_MODE = 0,
  parameter int AW          = $clog2(SCREENWIDTH),
  localparam int PW         = CHANNELS * COLORDEPTH
) (
  input  logic                             clk,
  input  logic                             rst,
  line_buffer_mc_if.slave                  pix_i,
  output logic                             dv_o,
  output logic                             hs_o,
  output logic                             vs_o,
  output logic [BUF_DEPTH-1:0][PW-1:0]     buff_o,
  output logic [BUF_DEPTH-1:0]             row_valid_o,
  output logic                             overflow_o
);

  localparam int LW = $clog2(BUF_DEPTH);
  localparam logic [AW:0]   COL_MAX = (AW+1)'(SCREENWIDTH);
  localparam logic [LW-1:0] LD_MAX  = LW'(BUF_DEPTH - 1);

  logic [AW:0]                   col_q, col_d;
  logic [LW-1:0]                 ld_q, ld_d;
  logic [LW-1:0]                 ldo_q;
  logic                          ovf_q, ovf_d;
  logic                          dv_q, hs_q, vs_q;
  logic                          ovp_q;
  logic [PW-1:0]                 row0_q;
  logic [BUF_DEPTH-1:0]          rv_q, rv_d;
  logic [BUF_DEPTH-1:0][PW-1:0]  rdw;
  logic [BUF_DEPTH-1:1][PW-1:0]  rd;
  logic [BUF_DEPTH-1:0][PW-1:0]  raw;

  logic          in_rng;
  logic          ov_px;
  logic          wr_en;
  logic          vs_rise;
  logic          line_end;
  logic [AW-1:0] addr;

  assign in_rng   = pix_i.dv && (col_q < COL_MAX);
  assign ov_px    = pix_i.dv && !in_rng;
  assign wr_en    = in_rng && !rst;
  assign vs_rise  = pix_i.vs && !vs_q;
  assign line_end = dv_q && !pix_i.dv;
  assign addr     = col_q[AW-1:0];
  assign rdw[0]   = pix_i.data;

  // Each RAM reads before write, so row k-1's old word shifts into row k.
  for (genvar k = 1; k < BUF_DEPTH; k++) begin : g_mem
    logic [PW-1:0] mem [SCREENWIDTH];
    logic [PW-1:0] rd_q;

    assign rdw[k] = mem[addr];
    assign rd[k]  = rd_q;

    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem[addr] <= rdw[k-1];
        rd_q      <= rdw[k];
      end
    end
  end

  always_comb begin
    col_d = '0;
    if (pix_i.dv)
      col_d = (col_q == COL_MAX) ? col_q : col_q + 1'b1;

    ld_d = ld_q;
    if (vs_rise)
      ld_d = '0;
    else if (line_end && ld_q != LD_MAX)
      ld_d = ld_q + 1'b1;

    ovf_d = ovf_q;
    if (vs_rise)
      ovf_d = 1'b0;
    if (ov_px)
      ovf_d = 1'b1;

    rv_d = '0;
    for (int k = 0; k < BUF_DEPTH; k++)
      rv_d[k] = (k <= int'(ld_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q  <= '0;
      ld_q   <= '0;
      ldo_q  <= '0;
      ovf_q  <= 1'b0;
      dv_q   <= 1'b0;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      ovp_q  <= 1'b0;
      row0_q <= '0;
      rv_q   <= '0;
    end else begin
      col_q  <= col_d;
      ld_q   <= ld_d;
      ldo_q  <= ld_q;
      ovf_q  <= ovf_d;
      dv_q   <= pix_i.dv;
      hs_q   <= pix_i.hs;
      vs_q   <= pix_i.vs;
      ovp_q  <= ov_px;
      row0_q <= pix_i.data;
      rv_q   <= rv_d;
    end
  end

  // Invalid rows are zeroed or copy the oldest valid row.
  always_comb begin
    raw    = '0;
    buff_o = '0;
    raw[0] = row0_q;
    for (int k = 1; k < BUF_DEPTH; k++)
      raw[k] = ovp_q ? '0 : rd[k];
    for (int k = 0; k < BUF_DEPTH; k++) begin
      if (rv_q[k])
        buff_o[k] = raw[k];
      else if (BORDER_MODE == 1)
        buff_o[k] = raw[ldo_q];
      else
        buff_o[k] = '0;
    end
  end

  assign dv_o        = dv_q;
  assign hs_o        = hs_q;
  assign vs_o        = vs_q;
  assign row_valid_o = rv_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_line_buffer_mc.sv
// Scoreboard bench for line_buffer_mc: zero-fill and replicate-border
// instances share one pixel stream and a reference line model.
module tb_line_buffer_mc;
  localparam int PW = 24;
  localparam int BD = 3;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  line_buffer_mc_if #(.W(PW)) bus ();

  logic                  dv0, hs0, vs0, ov0;
  logic                  dv1, hs1, vs1, ov1;
  logic [BD-1:0][PW-1:0] b0, b1;
  logic [BD-1:0]         rv0, rv1;

  line_buffer_mc #(
    .SCREENWIDTH(SW), .BUF_DEPTH(BD), .BORDER_MODE(0)
  ) u_zero (
    .clk(clk), .rst(rst), .pix_i(bus),
    .dv_o(dv0), .hs_o(hs0), .vs_o(vs0),
    .buff_o(b0), .row_valid_o(rv0), .overflow_o(ov0)
  );

  line_buffer_mc #(
    .SCREENWIDTH(SW), .BUF_DEPTH(BD), .BORDER_MODE(1)
  ) u_repl (
    .clk(clk), .rst(rst), .pix_i(bus),
    .dv_o(dv1), .hs_o(hs1), .vs_o(vs1),
    .buff_o(b1), .row_valid_o(rv1), .overflow_o(ov1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] b0;
    logic [71:0] b1;
    logic [2:0]  rv;
    logic        ov;
  } exp_t;

  exp_t q[$];
  exp_t e;

  int errors = 0;
  int checks = 0;
  bit mon_en = 0;

  logic [PW-1:0] h1 [SW];
  logic [PW-1:0] h2 [SW];
  int  col_m = 0;
  int  ld_m  = 0;
  bit  ovf_m = 0;
  bit  dvp   = 0;
  bit  vsp   = 0;
  bit  edv   = 0;
  bit  ehs   = 0;
  bit  evs   = 0;
  int  ln    = 0;

  task automatic chk(input string tag, input logic [71:0] got,
                     input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] pix(input int l, input int c);
    return {l[7:0], c[7:0], 8'hAA};
  endfunction

  task automatic cyc(input bit dv, input bit hs, input bit vs,
                     input logic [PW-1:0] d);
    exp_t x;
    logic [PW-1:0] r [3];
    bit vr, le;
    vr = vs && !vsp;
    le = dvp && !dv;
    x.b0 = '0;
    x.b1 = '0;
    x.rv = '0;
    if (dv) begin
      r[0] = d;
      r[1] = '0;
      r[2] = '0;
      if (col_m < SW) begin
        r[1] = h1[col_m];
        r[2] = h2[col_m];
      end
      for (int k = 0; k < 3; k++) begin
        x.rv[k] = (k <= ld_m);
        x.b0[k*24 +: 24] = x.rv[k] ? r[k] : 24'h0;
        x.b1[k*24 +: 24] = x.rv[k] ? r[k] : r[ld_m];
      end
      if (col_m < SW) begin
        h2[col_m] = h1[col_m];
        h1[col_m] = d;
      end
    end
    ovf_m = (vr ? 1'b0 : ovf_m) | (dv && col_m >= SW);
    x.ov = ovf_m;
    if (dv) q.push_back(x);
    col_m = dv ? ((col_m == SW) ? SW : col_m + 1) : 0;
    if (vr) ld_m = 0;
    else if (le && ld_m < 2) ld_m++;
    dvp = dv;
    vsp = vs;
    bus.dv = dv;
    bus.hs = hs;
    bus.vs = vs;
    bus.data = d;
    @(posedge clk);
    #1;
    edv = dv;
    ehs = hs;
    evs = vs;
  endtask

  task automatic line(input int n, input bit vs_end);
    for (int c = 0; c < n; c++) cyc(1'b1, 1'b0, 1'b0, pix(ln, c));
    cyc(1'b0, 1'b1, vs_end, '0);
    cyc(1'b0, 1'b1, 1'b0, '0);
    ln++;
  endtask

  task automatic frame();
    cyc(1'b0, 1'b0, 1'b1, '0);
    cyc(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.dv = 1'b0;
    bus.hs = 1'b0;
    bus.vs = 1'b0;
    bus.data = '0;
    @(posedge clk);
    #1;
    edv = 0;
    ehs = 0;
    evs = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    col_m = 0;
    ld_m = 0;
    ovf_m = 0;
    dvp = 0;
    vsp = 0;
    @(negedge clk);
    chk("rst_buff_z", b0, '0);
    chk("rst_buff_r", b1, '0);
    chk("rst_rv_z", rv0, '0);
    chk("rst_rv_r", rv1, '0);
    chk("rst_ovf_z", ov0, '0);
    chk("rst_ovf_r", ov1, '0);
    chk("rst_dv", dv0, '0);
    chk("rst_hs", hs0, '0);
    chk("rst_vs", vs0, '0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("dv_o_z", dv0, edv);
      chk("dv_o_r", dv1, edv);
      chk("hs_o", hs0, ehs);
      chk("vs_o", vs0, evs);
      if (dv0) begin
        chk("sb_avail", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("buff_z", b0, e.b0);
          chk("buff_r", b1, e.b1);
          chk("rv_z", rv0, e.rv);
          chk("rv_r", rv1, e.rv);
          chk("ovf_z", ov0, e.ov);
          chk("ovf_r", ov1, e.ov);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < SW; i++) begin
      h1[i] = '0;
      h2[i] = '0;
    end
    bus.dv = 1'b0;
    bus.hs = 1'b0;
    bus.vs = 1'b0;
    bus.data = '0;
    do_reset();
    mon_en = 1;

    frame();
    repeat (3) line(8, 1'b0);

    frame();
    repeat (3) line(8, 1'b0);

    line(10, 1'b0);
    line(8, 1'b0);
    line(8, 1'b0);

    frame();
    line(8, 1'b0);
    line(8, 1'b1);
    line(8, 1'b0);

    frame();
    line(10, 1'b0);
    line(8, 1'b0);
    for (int c = 0; c < 3; c++) cyc(1'b1, 1'b0, 1'b0, pix(ln, c));
    ln++;
    do_reset();
    line(8, 1'b0);
    line(8, 1'b0);

    repeat (3) cyc(1'b0, 1'b0, 1'b0, '0);
    chk("sb_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
